// File: rtl/if_pd_fetch_queue.sv
// if_pd_fetch_queue: DEPTH-entry IF->PD fetch packet queue with valid/ready flow control,
// delay-slot tagging across entries, whole-queue flush and a registered mispredict flag.
module if_pd_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PAYLOAD_W = 72,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 refresh,
    input  logic                 ex_af_bp_fail,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic                 in_branch,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_pc_8,
    output logic                 out_bd,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_fail_flushed,
    output logic [CNT_W-1:0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 33 + PAYLOAD_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_branch_q, last_branch_d, fail_q;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    assign in_ready  = count_q != CNT_W'(DEPTH);
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready && !refresh;
    assign pop       = out_valid && out_ready && !refresh;

    always_comb begin
        wr_ptr_d      = refresh ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d      = refresh ? '0 : rd_ptr_q + PTR_W'(pop);
        count_d       = refresh ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        last_branch_d = refresh ? 1'b0 : (push ? in_branch : last_branch_q);
    end

    // Array is never cleared; stale entries stay hidden behind count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_pc, last_branch_q, in_payload};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_branch_q <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            last_branch_q <= last_branch_d;
            fail_q        <= ex_af_bp_fail;
        end
    end

    assign head             = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_pc           = head[ENT_W-1 -: 32];
    assign out_bd           = head[PAYLOAD_W];
    assign out_payload      = head[PAYLOAD_W-1:0];
    assign out_pc_8         = out_pc + 32'd8;
    assign out_fail_flushed = fail_q;
    assign count            = count_q;
endmodule

// File: doc/if_pd_fetch_queue.md
Name: if_pd_fetch_queue

Overview:
Parametrised successor to the single-entry IF->PD segment register. It replaces that register with a DEPTH-entry circular queue of fetch packets, so IF can keep fetching while PD stalls. Flow control is valid/ready on both sides. The queue also tracks branch-delay-slot membership across entries, supports whole-queue flush, and forwards the registered back-end mispredict flag. It sits between the IF stage (BTB/gshare lookup) and the PD (predecode) stage.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2.
PAYLOAD_W, 72, opaque per-entry sideband bits (addr_error, inst_req, btb hit/target/index, gshare take/index), concatenated by the caller.
CNT_W, $clog2(DEPTH)+1, width of the occupancy count; derived, never overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge.
resetn  in  1  asynchronous active-low reset.
refresh  in  1  synchronous flush of all entries (exception / redirect).
ex_af_bp_fail  in  1  mispredict detected at EX or later.
in_valid  in  1  IF presents a packet.
in_ready  out  1  queue can accept; equals !full.
in_pc  in  32  PC of the incoming packet.
in_branch  in  1  incoming instruction is a branch/jump (predecoded hint from IF).
in_payload  in  PAYLOAD_W  incoming sideband bits.
out_valid  out  1  head entry valid; equals !empty.
out_ready  in  1  PD consumes the head entry.
out_pc  out  32  PC of the head entry.
out_pc_8  out  32  out_pc + 8, mod 2^32.
out_bd  out  1  head entry is a delay slot (previously enqueued entry was a branch).
out_payload  out  PAYLOAD_W  sideband bits of the head entry.
out_fail_flushed  out  1  ex_af_bp_fail delayed by one cycle.
count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x (32 + 1 + PAYLOAD_W) array.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count is a separate register.
  - full = (count == DEPTH); empty = (count == 0).
- Enqueue:
  - An entry is accepted when in_valid && in_ready && !refresh.
  - The entry written is {in_pc, bd_next, in_payload}. bd_next is the value of last_branch before this edge.
  - On the same edge, last_branch <= in_branch.
  - last_branch changes only on an accepted enqueue or on a flush.
- Dequeue:
  - An entry is retired when out_valid && out_ready && !refresh.
  - out_* are driven combinationally from the entry at rd_ptr.
  - When empty, out_pc, out_bd and out_payload are 0 (mask on !out_valid).
- Latency: 1 cycle from acceptance to visibility on out_*; there is no empty-queue bypass.
- Simultaneous enqueue and dequeue:
  - Both pointers advance and count is unchanged.
  - When full, in_ready=0, so no enqueue occurs even if a dequeue happens that cycle.
  - When empty, only the enqueue occurs; the new entry appears next cycle.
- Flush (refresh=1):
  - Next edge: wr_ptr=rd_ptr=0, count=0, last_branch=0.
  - Any in_valid or out_ready that cycle is ignored.
  - Array contents are not cleared; they are hidden by count.
- out_fail_flushed <= ex_af_bp_fail every edge, regardless of refresh or flow control.
- Reset (async, resetn=0):
  - Immediately: wr_ptr=0, rd_ptr=0, count=0, last_branch=0, out_fail_flushed=0.
  - Resulting outputs: out_valid=0, in_ready=1, out_pc=0, out_bd=0, out_payload=0, out_pc_8=8, count=0.
  - Reset mid-operation discards all entries.
- Occupancy invariant: count always equals the number of accepted enqueues minus retired dequeues since the last flush or reset. count never exceeds DEPTH and never underflows.

Test Plan:
- Reset then idle: enqueue pc 0xBFC00000 -> out_valid=1 next cycle; out_pc=0xBFC00000, out_pc_8=0xBFC00008, out_bd=0, count=1.
- Delay-slot tracking: enqueue 0x100 (in_branch=1), 0x104 (in_branch=0), 0x108 -> out_bd sequence on dequeue is 0, 1, 0.
- Fill/wrap, DEPTH=4, out_ready=0:
  - Enqueue 0x0..0xC -> count=4, in_ready=0; a fifth in_valid is dropped.
  - Then out_ready=1 with continuous enqueue of 0x10.. for 10 cycles -> PCs leave in order 0x0, 0x4, ... with no gap or duplicate across pointer wrap.
- Simultaneous enqueue+dequeue at count=2 -> count stays 2, order preserved; same at count=4 -> only the dequeue happens, count=3.
- Flush with queue holding 3 entries, last entry a branch, in_valid=1 on the refresh cycle:
  - Next cycle: count=0, out_valid=0.
  - The following enqueue shows out_bd=0.
- ex_af_bp_fail pulse at cycle N (concurrent with refresh) -> out_fail_flushed=1 only at cycle N+1.
- Async reset asserted mid-stream with count=3 -> outputs take reset values before the next clock edge.
